// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - State encoding of the IDLE/ISSUE/RESP access sequencer.
//   - Requester index constants used by the picker and the sequencer.
package dmem_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic REQ_P0 = 1'b0;
  localparam logic REQ_P1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StIssue = S_ISSUE,
    StResp  = S_RESP
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker.
// Ports:
//   req_i[1:0]  request vector, bit n = requester n
//   last_gnt_i  index of the most recently granted requester
//   rr_en_i     1 = round-robin on contention, 0 = requester 0 always wins
//   win_o       index of the winning requester (meaningful when any_req_o)
//   any_req_o   at least one request is asserted
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  input  logic       rr_en_i,
  output logic       win_o,
  output logic       any_req_o
);

  always_comb begin
    any_req_o = |req_i;
    win_o     = REQ_P0;
    unique case (req_i)
      2'b10:   win_o = REQ_P1;
      // Contention: alternate away from the last winner when round-robin is on.
      2'b11:   win_o = rr_en_i ? ~last_gnt_i : REQ_P0;
      default: win_o = REQ_P0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester controller for the single-port data memory.
// Requester 0 is the pipeline load/store path, requester 1 the loader/debug DMA.
// Each access runs IDLE -> ISSUE (-> RESP for loads) -> IDLE; every output is registered.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pN_req/we/addr/wdata     requester N command, held until pN_gnt
//   pN_gnt                   one-cycle pulse while the command is on the memory bus
//   pN_rvalid/pN_rdata       one-cycle load-result pulse; rdata holds until the next pulse
//   mem_en/we/addr/wdata     memory command (driven during ISSUE)
//   mem_rdata                memory read data, valid the cycle after a read command
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              last_gnt_q;
  logic              cmd_idx_q;
  logic              p0_gnt_q, p1_gnt_q;
  logic              p0_rvalid_q, p1_rvalid_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              win;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req_i      ({p1_req, p0_req}),
    .last_gnt_i (last_gnt_q),
    .rr_en_i    (RR_EN),
    .win_o      (win),
    .any_req_o  (any_req)
  );

  // Winner's command fields, only looked at in IDLE.
  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (win == REQ_P1) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  // The registered memory outputs double as the command registers: they are loaded on the
  // IDLE edge so the command is on the bus for the whole ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_gnt_q  <= REQ_P1;
      cmd_idx_q   <= REQ_P0;
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Pulses default low; address/data simply hold.
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            cmd_idx_q   <= win;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            p0_gnt_q    <= (win == REQ_P0);
            p1_gnt_q    <= (win == REQ_P1);
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          last_gnt_q <= cmd_idx_q;
          // mem_we_q still holds this access's direction during ISSUE.
          state_q    <= mem_we_q ? StIdle : StResp;
        end
        StResp: begin
          if (cmd_idx_q == REQ_P0) begin
            p0_rdata_q  <= mem_rdata;
            p0_rvalid_q <= 1'b1;
          end else begin
            p1_rdata_q  <= mem_rdata;
            p1_rvalid_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign p0_gnt    = p0_gnt_q;
  assign p1_gnt    = p1_gnt_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
